// File: rtl/i2c_slave_regfile.sv
// I2C target at a single 7-bit address. It maps I2C writes and reads onto a register-file
// port that has an auto-incrementing 8-bit pointer. SDA is open-drain and SCL is never stretched.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2C,
  parameter int         FILTER_LEN = 3
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] reg_addr_o,
  output logic       wr_o,
  output logic [7:0] wr_data_o,
  output logic       rd_o,
  input  logic [7:0] rd_data_i,
  output logic       busy_o
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  localparam logic [2:0] FL_M1 = 3'(FILTER_LEN - 1);

  // Bit 1 carries SCL and bit 0 carries SDA throughout the input path.
  logic [1:0] sync_p0, sync_p1;
  logic [1:0] filt_p2, filt_p3;
  logic [2:0] flt_cnt [2];

  logic       scl_f, scl_q, sda_f, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  logic       addr_hit;

  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [6:0] sr;
  logic       rw;
  logic       ack_on;
  logic       inc_pend;
  logic       sda_drv_low;

  // Stage p0/p1: two-flop synchronizer; the bus idles high
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
    end else begin
      sync_p0 <= {scl_pad_i, sda_pad_i};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: glitch filter (a level change needs FILTER_LEN equal samples); p3 keeps the previous filtered level for edge detection
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      filt_p2 <= 2'b11;
      filt_p3 <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= 3'd0;
    end else begin
      filt_p3 <= filt_p2;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          flt_cnt[i] <= 3'd0;
        end else if (flt_cnt[i] == FL_M1) begin
          filt_p2[i] <= sync_p1[i];
          flt_cnt[i] <= 3'd0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 3'd1;
        end
      end
    end
  end

  assign scl_f = filt_p2[1];
  assign scl_q = filt_p3[1];
  assign sda_f = filt_p2[0];
  assign sda_q = filt_p3[0];

  // START/STOP require SCL high on both samples, so an SCL edge in the same cycle wins.
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  assign byte_in  = {sr, sda_f};
  assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'd0);

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = ~sda_drv_low;

  // Stage p4: protocol FSM and register-file port
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state       <= ST_IDLE;
      bit_cnt     <= 4'd0;
      sr          <= 7'd0;
      rw          <= 1'b0;
      ack_on      <= 1'b0;
      inc_pend    <= 1'b0;
      sda_drv_low <= 1'b0;
      reg_addr_o  <= 8'd0;
      wr_o        <= 1'b0;
      wr_data_o   <= 8'd0;
      rd_o        <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      wr_o <= 1'b0;
      rd_o <= 1'b0;
      if (inc_pend) begin
        reg_addr_o <= reg_addr_o + 8'd1;
        inc_pend   <= 1'b0;
      end

      if (scl_rise) begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            sr <= byte_in[6:0];
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              case (state)
                ST_ADDR: begin
                  if (addr_hit) begin
                    state  <= ST_ADDR_ACK;
                    busy_o <= 1'b1;
                    rw     <= sda_f;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end
                ST_PTR: begin
                  reg_addr_o <= byte_in;
                  state      <= ST_PTR_ACK;
                end
                default: begin
                  wr_o      <= 1'b1;
                  wr_data_o <= byte_in;
                  inc_pend  <= 1'b1;
                  state     <= ST_WDATA_ACK;
                end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_RDATA: bit_cnt <= bit_cnt + 4'd1;
          ST_RDATA_ACK: begin
            if (!sda_f) begin
              inc_pend <= 1'b1;
              ack_on   <= 1'b1;
            end else begin
              state <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (!ack_on) begin
              sda_drv_low <= 1'b1;
              ack_on      <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              bit_cnt <= 4'd0;
              if (state == ST_ADDR_ACK && rw) begin
                sr          <= rd_data_i[6:0];
                sda_drv_low <= ~rd_data_i[7];
                rd_o        <= 1'b1;
                state       <= ST_RDATA;
              end else begin
                sda_drv_low <= 1'b0;
                state       <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (bit_cnt == 4'd8) begin
              sda_drv_low <= 1'b0;
              bit_cnt     <= 4'd0;
              state       <= ST_RDATA_ACK;
            end else begin
              sda_drv_low <= ~sr[6];
              sr          <= {sr[5:0], 1'b0};
            end
          end
          ST_RDATA_ACK: begin
            if (ack_on) begin
              ack_on      <= 1'b0;
              bit_cnt     <= 4'd0;
              sr          <= rd_data_i[6:0];
              sda_drv_low <= ~rd_data_i[7];
              rd_o        <= 1'b1;
              state       <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end else if (start_det) begin
        state       <= ST_ADDR;
        bit_cnt     <= 4'd0;
        ack_on      <= 1'b0;
        sda_drv_low <= 1'b0;
        busy_o      <= 1'b0;
      end else if (stop_det) begin
        state       <= ST_IDLE;
        bit_cnt     <= 4'd0;
        ack_on      <= 1'b0;
        sda_drv_low <= 1'b0;
        busy_o      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile. A bus-level I2C master drives the DUT, and a transaction
// model predicts the register writes, the pointer and the read bytes.
module tb_i2c_slave_regfile;
  localparam logic [6:0] SLAVE_ADDR = 7'h2C;
  localparam int Q = 100;

  logic       wb_clk_i = 1'b0;
  logic       arst_i = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_pad_o, sda_padoen_o, wr_o, rd_o, busy_o;
  logic [7:0] reg_addr_o, wr_data_o, rd_data_i;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ptr_m = 8'd0;
  logic [15:0] exp_wr[$];
  int          exp_rd = 0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;
  logic [7:0]  wbuf[4];

  assign sda_bus   = sda_m & (sda_padoen_o | sda_pad_o);
  assign rd_data_i = reg_addr_o + 8'h40;

  always #5 wb_clk_i = ~wb_clk_i;

  i2c_slave_regfile #(.SLAVE_ADDR(SLAVE_ADDR), .FILTER_LEN(3)) dut (
    .wb_clk_i(wb_clk_i), .arst_i(arst_i), .scl_pad_i(scl_m), .sda_pad_i(sda_bus),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .reg_addr_o(reg_addr_o),
    .wr_o(wr_o), .wr_data_o(wr_data_o), .rd_o(rd_o), .rd_data_i(rd_data_i), .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle check of the strobes against the transaction model
  always @(negedge wb_clk_i) begin
    if (arst_i) begin
      chk("sda_pad_o_const", sda_pad_o, 1'b0);
      chk("wr_rd_exclusive", wr_o & rd_o, 1'b0);
      if (wr_o) begin
        chk("wr_one_clock", prev_wr, 1'b0);
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr: addr 0x%0h data 0x%0h, expected no write", reg_addr_o, wr_data_o);
        end else begin
          chk("wr_addr_data", {reg_addr_o, wr_data_o}, exp_wr.pop_front());
        end
      end
      if (rd_o) begin
        chk("rd_one_clock", prev_rd, 1'b0);
        checks++;
        if (exp_rd == 0) begin
          errors++;
          $display("FAIL unexpected_rd: addr 0x%0h, expected no read strobe", reg_addr_o);
        end else exp_rd--;
      end
    end
    prev_wr = wr_o;
    prev_rd = rd_o;
  end

  task automatic start_c();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic bit_c(input logic b, output logic s);
    sda_m = b; #Q; scl_m = 1'b1; #Q; s = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  // Sends the top nbits of b. When with_ack is set, it then clocks the ACK bit; a one-clock SCL glitch follows bit glitch_at when glitch_at >= 1.
  task automatic send_byte(input logic [7:0] b, input int nbits, input bit with_ack,
                           input int glitch_at, output logic acked);
    logic s;
    acked = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bit_c(b[7-i], s);
      if (i + 1 == glitch_at) begin
        scl_m = 1'b1; #10; scl_m = 1'b0; #Q;
      end
    end
    if (with_ack) begin
      bit_c(1'b1, s);
      acked = ~s;
    end
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_c(1'b1, s);
      b = {b[6:0], s};
    end
    bit_c(~mack, s);
  endtask

  task automatic write_txn(input logic [6:0] a, input logic [7:0] p, input int n, input int glitch_at);
    logic ack;
    logic hit;
    hit = (a == SLAVE_ADDR) && (a != 7'd0);
    if (hit) begin
      ptr_m = p;
      for (int i = 0; i < n; i++) begin
        exp_wr.push_back({ptr_m, wbuf[i]});
        ptr_m = ptr_m + 8'd1;
      end
    end
    start_c();
    send_byte({a, 1'b0}, 8, 1'b1, 0, ack);
    chk("addr_ack", ack, hit);
    chk("busy_after_addr", busy_o, hit);
    if (hit) begin
      send_byte(p, 8, 1'b1, 0, ack);
      chk("ptr_ack", ack, 1'b1);
      for (int i = 0; i < n; i++) begin
        send_byte(wbuf[i], 8, 1'b1, (i == 0) ? glitch_at : 0, ack);
        chk("data_ack", ack, 1'b1);
      end
    end
    stop_c();
    #Q;
    chk("busy_after_stop", busy_o, 1'b0);
    chk("sda_released_idle", sda_padoen_o, 1'b1);
    chk("ptr_after_write", reg_addr_o, ptr_m);
    chk("writes_outstanding", exp_wr.size(), 0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;

    #7;
    chk("rst_sda_padoen", sda_padoen_o, 1'b1);
    chk("rst_reg_addr", reg_addr_o, 8'h00);
    chk("rst_strobes", {wr_o, rd_o, busy_o}, 3'b000);
    chk("rst_wr_data", wr_data_o, 8'h00);
    #20 arst_i = 1'b1;
    #Q;

    // Single write 0xA5 to register 0x10
    wbuf[0] = 8'hA5;
    write_txn(SLAVE_ADDR, 8'h10, 1, 0);
    chk("single_ptr_literal", reg_addr_o, 8'h11);

    // Burst write wrapping the pointer past 0xFF
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_txn(SLAVE_ADDR, 8'hFE, 3, 0);
    chk("burst_ptr_literal", reg_addr_o, 8'h01);

    // Pointer write, repeated START, then read two bytes
    ptr_m  = 8'h20;
    exp_rd = exp_rd + 2;
    start_c();
    send_byte({SLAVE_ADDR, 1'b0}, 8, 1'b1, 0, ack);
    chk("rd_addr_w_ack", ack, 1'b1);
    send_byte(8'h20, 8, 1'b1, 0, ack);
    chk("rd_ptr_ack", ack, 1'b1);
    start_c();
    chk("busy_cleared_by_sr", busy_o, 1'b0);
    send_byte({SLAVE_ADDR, 1'b1}, 8, 1'b1, 0, ack);
    chk("rd_addr_r_ack", ack, 1'b1);
    recv_byte(1'b1, b);
    chk("rd_byte0_model", b, ptr_m + 8'h40);
    chk("rd_byte0_literal", b, 8'h60);
    ptr_m = ptr_m + 8'd1;
    recv_byte(1'b0, b);
    chk("rd_byte1_model", b, ptr_m + 8'h40);
    chk("rd_byte1_literal", b, 8'h61);
    chk("sda_released_after_nack", sda_padoen_o, 1'b1);
    chk("busy_until_stop", busy_o, 1'b1);
    stop_c();
    #Q;
    chk("rd_ptr_model", reg_addr_o, ptr_m);
    chk("rd_ptr_literal", reg_addr_o, 8'h21);
    chk("rd_strobes_outstanding", exp_rd, 0);
    chk("rd_busy_after_stop", busy_o, 1'b0);

    // Wrong address and general call are both ignored
    write_txn(7'h2D, 8'h00, 0, 0);
    write_txn(7'h00, 8'h00, 0, 0);
    chk("ptr_kept_after_nack", reg_addr_o, 8'h21);

    // One-clock SCL glitch inside a data byte
    wbuf[0] = 8'h3C;
    write_txn(SLAVE_ADDR, 8'h40, 1, 3);
    chk("glitch_ptr_literal", reg_addr_o, 8'h41);

    // STOP after four data bits: no write strobe, pointer left at 0x30
    ptr_m = 8'h30;
    start_c();
    send_byte({SLAVE_ADDR, 1'b0}, 8, 1'b1, 0, ack);
    chk("abort_addr_ack", ack, 1'b1);
    send_byte(8'h30, 8, 1'b1, 0, ack);
    chk("abort_ptr_ack", ack, 1'b1);
    send_byte(8'hF0, 4, 1'b0, 0, ack);
    stop_c();
    #Q;
    chk("abort_ptr", reg_addr_o, ptr_m);
    chk("abort_busy", busy_o, 1'b0);

    // Asynchronous reset while the ACK is being driven
    start_c();
    send_byte({SLAVE_ADDR, 1'b0}, 8, 1'b0, 0, ack);
    chk("ack_driven_before_reset", sda_padoen_o, 1'b0);
    chk("busy_before_reset", busy_o, 1'b1);
    arst_i = 1'b0;
    #1;
    chk("arst_sda_released", sda_padoen_o, 1'b1);
    chk("arst_reg_addr", reg_addr_o, 8'h00);
    chk("arst_strobes", {wr_o, rd_o, busy_o}, 3'b000);
    chk("arst_wr_data", wr_data_o, 8'h00);
    chk("arst_sda_pad_o", sda_pad_o, 1'b0);
    #9;
    ptr_m = 8'h00;
    #20 arst_i = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    #Q;

    // Recovery transaction after reset
    wbuf[0] = 8'h5A;
    write_txn(SLAVE_ADDR, 8'h05, 1, 0);
    chk("recovery_ptr_literal", reg_addr_o, 8'h06);

    #Q;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
